// File: rtl/fixed_pkg.sv
// Shared definitions for the sign-magnitude fixed-point arithmetic blocks.
// This package covers the word format, the magnitude limit and the divider FSM states.
package fixed_pkg;
  localparam int INT_BITS_DEF  = 8;
  localparam int FRAC_BITS_DEF = 8;
  localparam int W = 1 + INT_BITS_DEF + FRAC_BITS_DEF;
  localparam int N = INT_BITS_DEF + 2 * FRAC_BITS_DEF;
  localparam logic [W-2:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module fixed_div_step #(
  parameter int MW = 16
) (
  input  logic [MW-1:0] rem,
  input  logic          d_bit,
  input  logic [MW-1:0] mb,
  output logic [MW-1:0] rem_next,
  output logic          q_bit
);
  logic [MW:0] shifted;
  logic [MW:0] diff;

  assign shifted = {rem, d_bit};
  assign diff    = shifted - {1'b0, mb};
  assign q_bit   = (shifted >= {1'b0, mb});
  // The remainder stays below mb, so the kept value always fits in MW bits.
  assign rem_next = q_bit ? MW'(diff) : MW'(shifted);
endmodule

// File: rtl/fixed_div.sv
// Sequential sign-magnitude fixed-point divider: ab = a / b.
// Fixed latency, one quotient bit per cycle, and saturation on overflow or divide by zero.
module fixed_div
  import fixed_pkg::*;
#(
  parameter int INT_BITS  = INT_BITS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [INT_BITS+FRAC_BITS:0]     a,
  input  logic [INT_BITS+FRAC_BITS:0]     b,
  output logic                            busy,
  output logic                            valid,
  output logic [INT_BITS+FRAC_BITS:0]     ab,
  output logic                            clip_int,
  output logic                            clip_frac,
  output logic                            div_zero
);
  localparam int MW = INT_BITS + FRAC_BITS;
  localparam int NL = INT_BITS + 2 * FRAC_BITS;
  localparam int CW = $clog2(NL);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [NL-1:0]   dvd_reg;
  logic [NL-1:0]   quo_reg;
  logic [MW-1:0]   rem_reg;
  logic [MW-1:0]   mb_reg;
  logic            sign_reg;

  logic [MW-1:0]   rem_next;
  logic            q_bit;
  logic            res_dz;
  logic            res_ovf;
  logic [MW-1:0]   res_mag;
  logic            res_sign;

  fixed_div_step #(.MW(MW)) u_step (
    .rem      (rem_reg),
    .d_bit    (dvd_reg[NL-1]),
    .mb       (mb_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  // The result is formed from the final quotient and remainder while in DONE.
  always_comb begin
    res_dz   = (mb_reg == '0);
    res_ovf  = |quo_reg[NL-1:MW];
    res_mag  = (res_dz || res_ovf) ? '1 : quo_reg[MW-1:0];
    res_sign = sign_reg & (|res_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      dvd_reg  <= '0;
      quo_reg  <= '0;
      rem_reg  <= '0;
      mb_reg   <= '0;
      sign_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          dvd_reg  <= {a[MW-1:0], {FRAC_BITS{1'b0}}};
          mb_reg   <= b[MW-1:0];
          sign_reg <= a[MW] ^ b[MW];
          rem_reg  <= '0;
          quo_reg  <= '0;
          cnt_reg  <= CW'(NL - 1);
        end
        RUN: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[NL-2:0], q_bit};
          dvd_reg <= {dvd_reg[NL-2:0], 1'b0};
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      ab        <= '0;
      clip_int  <= 1'b0;
      clip_frac <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      valid <= (state_reg == DONE);
      if (state_reg == DONE) begin
        ab        <= {res_sign, res_mag};
        clip_int  <= res_dz | res_ovf;
        clip_frac <= ~res_dz & (|rem_reg);
        div_zero  <= res_dz;
      end
    end
  end
endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div: an arithmetic reference model is checked every cycle,
// and hand-computed vectors pin both the model and the DUT.
module tb_fixed_div;
  typedef struct packed {
    logic [16:0] ab;
    logic        ci;
    logic        cf;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] a = '0;
  logic [16:0] b = '0;
  logic        busy, valid, clip_int, clip_frac, div_zero;
  logic [16:0] ab;

  int   edge_n = 0;
  int   due = -100;
  int   lit_edge = -1;
  res_t pending = '0;
  res_t lit_exp = '0;
  res_t held = '0;
  int   n_checks = 0;
  int   n_pass = 0;

  fixed_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid     (valid),
    .ab        (ab),
    .clip_int  (clip_int),
    .clip_frac (clip_frac),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic res_t model(input logic [16:0] ta, input logic [16:0] tb);
    res_t        r;
    longint      ma, mb, q, rm;
    logic [15:0] mag;
    ma = longint'(ta[15:0]);
    mb = longint'(tb[15:0]);
    r  = '0;
    if (mb == 0) begin
      mag  = 16'hFFFF;
      r.ci = 1'b1;
      r.dz = 1'b1;
    end else begin
      q  = (ma * 256) / mb;
      rm = (ma * 256) % mb;
      if (q > 65535) begin
        mag  = 16'hFFFF;
        r.ci = 1'b1;
      end else begin
        mag = q[15:0];
      end
      r.cf = (rm != 0);
    end
    r.ab = {(ta[16] ^ tb[16]) && (mag != 16'd0), mag};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  // Single compare process: model-predicted handshake and held outputs every cycle.
  always @(negedge clk) begin
    bit exp_busy;
    if (!rst_n) begin
      held = '0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_out", {12'd0, ab, clip_int, clip_frac, div_zero}, 32'd0);
    end else begin
      exp_busy = (edge_n >= due - 25) && (edge_n < due);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("valid", {31'd0, valid}, {31'd0, edge_n == due});
      if (edge_n == due) held = pending;
      chk("ab", {15'd0, ab}, {15'd0, held.ab});
      chk("flags", {29'd0, clip_int, clip_frac, div_zero}, {29'd0, held.ci, held.cf, held.dz});
      if (edge_n == lit_edge) begin
        chk("lit_valid", {31'd0, valid}, 32'd1);
        chk("lit_ab", {15'd0, ab}, {15'd0, lit_exp.ab});
        chk("lit_flags", {29'd0, clip_int, clip_frac, div_zero},
            {29'd0, lit_exp.ci, lit_exp.cf, lit_exp.dz});
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives start for one edge; the operation is accepted only if the divider is idle at that edge.
  task automatic issue(input logic [16:0] ta, input logic [16:0] tb, input bit has_lit,
                       input logic [16:0] lab, input logic lci, input logic lcf, input logic ldz);
    int k;
    a = ta;
    b = tb;
    start = 1'b1;
    k = edge_n + 1;
    @(posedge clk);
    #2;
    start = 1'b0;
    a = 17'($urandom);
    b = 17'($urandom);
    if (k > due) begin
      due = k + 25;
      pending = model(ta, tb);
      if (has_lit) begin
        lit_edge = due;
        lit_exp  = '{ab: lab, ci: lci, cf: lcf, dz: ldz};
      end
      $display("op a=%05h b=%05h start@%0d expect valid@%0d", ta, tb, k, due);
    end else begin
      $display("op a=%05h b=%05h start@%0d ignored (busy)", ta, tb, k);
    end
  endtask

  initial begin
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(2);

    issue(17'h00200, 17'h00200, 1, 17'h00100, 0, 0, 0); wait_edges(25);
    issue(17'h10200, 17'h00080, 1, 17'h10400, 0, 0, 0); wait_edges(25);
    issue(17'h00100, 17'h00300, 1, 17'h00055, 0, 1, 0); wait_edges(25);
    issue(17'h08000, 17'h00040, 1, 17'h0FFFF, 1, 0, 0); wait_edges(25);
    issue(17'h18000, 17'h00040, 1, 17'h1FFFF, 1, 0, 0); wait_edges(25);
    issue(17'h10300, 17'h00000, 1, 17'h1FFFF, 1, 0, 1); wait_edges(25);
    issue(17'h00000, 17'h10500, 1, 17'h00000, 0, 0, 0); wait_edges(25);
    issue(17'h00001, 17'h0FF00, 1, 17'h00000, 0, 1, 0); wait_edges(30);

    issue(17'h10300, 17'h10000, 0, '0, 0, 0, 0); wait_edges(25);
    issue(17'h0FFFF, 17'h00001, 0, '0, 0, 0, 0); wait_edges(25);
    issue(17'h13456, 17'h10789, 0, '0, 0, 0, 0); wait_edges(25);
    issue(17'h00001, 17'h0FFFF, 0, '0, 0, 0, 0); wait_edges(27);

    // Start pulsed while busy must be ignored.
    issue(17'h00600, 17'h00200, 1, 17'h00300, 0, 0, 0);
    wait_edges(5);
    issue(17'h00100, 17'h00100, 0, '0, 0, 0, 0);
    wait_edges(22);

    // Reset in the middle of an operation: outputs clear, no valid follows.
    issue(17'h00700, 17'h00200, 0, '0, 0, 0, 0);
    wait_edges(10);
    rst_n = 1'b0;
    due = -100;
    lit_edge = -1;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(30);

    issue(17'h00200, 17'h00200, 1, 17'h00100, 0, 0, 0); wait_edges(28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
